// File: rtl/pc_target_table.sv
// rtl/pc_target_table.sv - branch target table with absolute/PC-relative entries
// Clears itself after reset, then serves registered lookups with write-through bypass.
module pc_target_table #(
   parameter int D  = 12,
   parameter int AW = 5
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [D-1:0]  wr_data,
   input  logic          wr_rel,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   input  logic [D-1:0]  pc_in,
   output logic [D-1:0]  target,
   output logic          rd_valid,
   output logic          miss,
   output logic          busy
);

   localparam int DEPTH = 2**AW;

   typedef enum logic {INIT, READY} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] clr_idx, clr_idx_nx;

   // entry layout: {valid, rel, value}
   logic [D+1:0]  mem [DEPTH];

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [D+1:0]  mem_wdata;
   logic          rd_fire;
   logic [D+1:0]  rd_entry;
   logic [D-1:0]  lookup;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= INIT;
         clr_idx <= '0;
      end else begin
         state   <= state_nx;
         clr_idx <= clr_idx_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      clr_idx_nx = clr_idx;
      mem_we     = 1'b0;
      mem_waddr  = wr_addr;
      mem_wdata  = {1'b1, wr_rel, wr_data};
      rd_fire    = 1'b0;
      busy       = 1'b0;
      case (state)
         INIT: begin
            busy       = 1'b1;
            mem_we     = 1'b1;
            mem_waddr  = clr_idx;
            mem_wdata  = '0;
            clr_idx_nx = clr_idx + AW'(1);
            if (&clr_idx)
               state_nx = READY;
         end
         READY: begin
            mem_we  = wr_en;
            rd_fire = rd_req;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   // a same-address write in the lookup cycle wins over the stored entry
   always_comb begin
      rd_entry = mem[rd_addr];
      if (wr_en && (wr_addr == rd_addr))
         rd_entry = {1'b1, wr_rel, wr_data};
      if (!rd_entry[D+1])
         lookup = '0;
      else if (rd_entry[D])
         lookup = pc_in + rd_entry[D-1:0];
      else
         lookup = rd_entry[D-1:0];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_valid <= 1'b0;
         target   <= '0;
         miss     <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         if (rd_fire) begin
            target <= lookup;
            miss   <= ~rd_entry[D+1];
         end
      end
   end

endmodule

// File: tb/tb_pc_target_table.sv
// tb/tb_pc_target_table.sv - directed scoreboard bench for pc_target_table
module tb_pc_target_table;

   localparam int D  = 12;
   localparam int AW = 5;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [D-1:0]  wr_data = '0;
   logic          wr_rel = 1'b0;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [D-1:0]  pc_in = '0;
   logic [D-1:0]  target;
   logic          rd_valid;
   logic          miss;
   logic          busy;

   int errors = 0;
   int checks = 0;
   bit hold_req = 1'b0;
   logic [D:0] exp_q [$];

   pc_target_table #(.D(D), .AW(AW)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rel(wr_rel),
      .rd_req(rd_req), .rd_addr(rd_addr), .pc_in(pc_in),
      .target(target), .rd_valid(rd_valid), .miss(miss), .busy(busy)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // one clock edge, then compare against the scoreboard
   task automatic cycle();
      logic [D:0] e;
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rd_valid", {31'd0, rd_valid}, 32'd1);
         chk("target", {20'd0, target}, {20'd0, e[D-1:0]});
         chk("miss", {31'd0, miss}, {31'd0, e[D]});
      end else begin
         chk("rd_valid_idle", {31'd0, rd_valid}, 32'd0);
      end
      wr_en = 1'b0;
      if (!hold_req) rd_req = 1'b0;
   endtask

   task automatic wr(input int addr, input logic [D-1:0] data, input logic rel);
      wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data; wr_rel = rel;
   endtask

   task automatic rd(input int addr, input logic [D-1:0] pc,
                     input logic [D-1:0] exp_t, input logic exp_m);
      rd_req = 1'b1; rd_addr = AW'(addr); pc_in = pc;
      exp_q.push_back({exp_m, exp_t});
   endtask

   task automatic wait_ready(input int exp_n);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (busy && n < 100);
      chk("busy_cycles", n, exp_n);
   endtask

   task automatic check_cleared(input string tag);
      #1;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
      chk({tag, "_target"}, {20'd0, target}, 32'd0);
      chk({tag, "_miss"}, {31'd0, miss}, 32'd0);
   endtask

   initial begin
      #3;
      check_cleared("reset");
      @(posedge Clk);
      #1;
      hold_req = 1'b1;
      rd_req = 1'b1; rd_addr = '0;
      Reset_n = 1'b1;
      wait_ready(32);
      hold_req = 1'b0;
      rd_req = 1'b0;

      wr(1, 12'h028, 1'b0);              cycle();
      rd(1, 12'h000, 12'h028, 1'b0);     cycle();
      rd(7, 12'h000, 12'h000, 1'b1);     cycle();
      cycle();

      wr(2, 12'hFFB, 1'b1);              cycle();
      wr(3, 12'h014, 1'b1);
      rd(2, 12'h004, 12'hFFF, 1'b0);     cycle();
      rd(3, 12'hFFF, 12'h013, 1'b0);     cycle();

      wr(4, 12'h0C4, 1'b0);
      rd(4, 12'h000, 12'h0C4, 1'b0);     cycle();
      wr(5, 12'h010, 1'b1);
      rd(5, 12'h100, 12'h110, 1'b0);     cycle();
      rd(1, 12'h000, 12'h028, 1'b0);     cycle();
      rd(4, 12'h000, 12'h0C4, 1'b0);     cycle();
      cycle();
      chk("hold_target", {20'd0, target}, 32'h0C4);
      chk("hold_miss", {31'd0, miss}, 32'd0);

      // reset in READY right after a lookup has been presented
      rd_req = 1'b1; rd_addr = 4;
      @(posedge Clk);
      #1;
      rd_req = 1'b0;
      Reset_n = 1'b0;
      exp_q.delete();
      check_cleared("ready_reset");
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      wait_ready(32);
      rd(1, 12'h000, 12'h000, 1'b1);     cycle();

      // reset ten cycles into INIT
      wr(1, 12'h055, 1'b0);              cycle();
      Reset_n = 1'b0;
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      repeat (10) cycle();
      chk("init_busy", {31'd0, busy}, 32'd1);
      Reset_n = 1'b0;
      check_cleared("init_reset");
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      wait_ready(32);
      rd(1, 12'h000, 12'h000, 1'b1);     cycle();
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_target_table.md
PC_TARGET_TABLE -- requirements
Module: pc_target_table

Interface
REQ-001 Parameter D, default 12, target/PC width in bits.
REQ-002 Parameter AW, default 5, table address width; DEPTH = 2**AW entries.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write strobe for one entry.
REQ-006 wr_addr  input  AW  entry index to write.
REQ-007 wr_data  input  D  absolute target, or two's-complement offset when wr_rel=1.
REQ-008 wr_rel  input  1  entry mode: 0 absolute, 1 PC-relative.
REQ-009 rd_req  input  1  lookup request.
REQ-010 rd_addr  input  AW  entry index to look up.
REQ-011 pc_in  input  D  current PC, used for relative entries.
REQ-012 target  output  D  registered lookup result.
REQ-013 rd_valid  output  1  one-cycle pulse: target is valid.
REQ-014 miss  output  1  qualified by rd_valid; looked-up entry never programmed.
REQ-015 busy  output  1  high while the table is clearing; requests are ignored.

Function
REQ-016 Each entry SHALL hold {valid, rel, value[D-1:0]}.
REQ-017 The FSM SHALL have two states, INIT and READY.
REQ-018 INIT SHALL clear one entry per cycle (valid=0, rel=0, value=0), from index 0 up to DEPTH-1, then move to READY.
REQ-019 The transition to READY SHALL occur on the edge that clears entry DEPTH-1. busy SHALL be high for exactly DEPTH cycles after reset release.
REQ-020 In INIT, wr_en and rd_req SHALL be ignored: no table update, rd_valid=0.
REQ-021 In READY, wr_en=1 SHALL set entry[wr_addr] = {1, wr_rel, wr_data} at the edge.
REQ-022 In READY, rd_req=1 at edge N SHALL give rd_valid=1 and target/miss in cycle N+1. This is a fixed 1-cycle latency, and back-to-back requests are accepted every cycle.
REQ-023 An absolute entry SHALL return target = value.
REQ-024 A relative entry SHALL return target = (pc_in + value) mod 2**D, where value is a D-bit two's-complement number and pc_in is sampled at the request edge. Wrap-around is silent.
REQ-025 An entry with valid=0 SHALL return target = 0 and miss = 1. Otherwise miss = 0.
REQ-026 A write and a read to the same address in the same cycle SHALL return the newly written data and mode (write-through bypass).
REQ-027 A write and a read to different addresses in the same cycle SHALL both complete independently.
REQ-028 When rd_valid=0, target and miss SHALL hold their last values.
REQ-029 READY SHALL persist until reset. There is no software-triggered clear.

Reset
REQ-030 Reset_n=0 SHALL immediately force: FSM=INIT, clear index=0, busy=1, rd_valid=0, target=0, miss=0.
REQ-031 Table contents need not be reset asynchronously. INIT SHALL re-clear every entry after release.
REQ-032 Reset asserted mid-INIT or mid-READY SHALL restart the full DEPTH-cycle clear, and any pending read is discarded.

Verification (D=12, AW=5)
REQ-033 Release reset, hold rd_req=1 with rd_addr=0 -> busy=1 for exactly 32 cycles, rd_valid=0 throughout, then busy=0.
REQ-034 Write addr 1 abs 0x028, then read addr 1 -> next cycle: target=0x028, rd_valid=1, miss=0. Read addr 7 (unwritten) -> target=0x000, miss=1.
REQ-035 Write addr 2 rel 0xFFB (-5), read with pc_in=0x004 -> target=0xFFF. Write addr 3 rel 0x014, read with pc_in=0xFFF -> target=0x013 (wrap).
REQ-036 Same cycle: wr_en to addr 4 with 0x0C4 abs, and rd_req to addr 4 -> next cycle target=0x0C4, miss=0. Back-to-back reads of addrs 1, 4 -> rd_valid high two cycles with 0x028, then 0x0C4.
REQ-037 Assert Reset_n=0 at cycle 10 of INIT, and separately in READY after programming -> outputs cleared at once, busy high 32 cycles after release, and a read of addr 1 afterwards gives miss=1.
